sd_cmd_resp_receiver: RTL
=========================

// Module: sd_cmd_resp_receiver
// PURPOSE
//  Host-side receiver for SD card responses on the CMD line; the counterpart of the command PISO.
//  Armed after a command is sent, it waits for the start bit and shifts in a 48-bit (R1/R3/R6/R7)
//  or 136-bit (R2) response. It checks the CRC7, transmission bit and end bit, then reports the
//  captured fields. A wait-for-start timeout bounds the no-response case.
// PARAMETERS
//  TIMEOUT_TICKS  64   max sample ticks in WAIT_START before timeout (NCR limit)
//  SHORT_BITS     48   short response frame length, start..end inclusive
//  LONG_BITS      136  long (R2) response frame length, start..end inclusive
// PORTS
//  clk          in   1    system clock, rising edge
//  rst          in   1    asynchronous reset, active-low; all state and outputs to reset values
//  start        in   1    1-cycle pulse: arm receiver; honoured only in IDLE
//  long_resp    in   1    sampled with start: 1 = expect 136-bit R2
//  crc_en       in   1    sampled with start: 0 = skip CRC compare (R3)
//  abort        in   1    synchronous abort: back to IDLE, no done pulse, flags untouched
//  sample_en    in   1    1-cycle tick: CMD line valid this cycle (SD clock sample point)
//  cmd_in       in   1    serial CMD line, MSB first
//  busy         out  1    high in any state except IDLE
//  done         out  1    1-cycle pulse: response complete or timed out
//  timeout      out  1    no start bit within TIMEOUT_TICKS
//  crc_err      out  1    received CRC7 != computed (only when crc_en latched 1)
//  frame_err    out  1    transmission bit != 0 or end bit != 1
//  resp_index   out  6    short: command index; long: 6'b111111 reserved field
//  resp_arg     out  32   short: argument bits [39:8] of frame
//  resp_long    out  127  long: CID/CSD bits [127:1] (CRC7 in [6:0])
// BEHAVIOUR
//  - Reset: busy, done, timeout, crc_err, frame_err = 0; resp_* = 0; state IDLE.
//  - All sampling happens only on cycles with sample_en=1; other cycles hold state.
//  - IDLE: start=1 -> latch long_resp/crc_en, clear flags and tick counter, go WAIT_START.
//    start in any other state is ignored.
//  - WAIT_START: on a tick, cmd_in=0 -> start bit, clear bit counter and CRC, go RECEIVE.
//    On a tick with cmd_in=1, increment counter. The tick that brings it to TIMEOUT_TICKS
//    -> timeout=1, go DONE. A start bit on that same tick wins over timeout.
//  - RECEIVE: each tick shifts cmd_in into the shift register (LSB in) and increments bit_cnt.
//    The start bit is not counted; frame ends after SHORT_BITS-1 or LONG_BITS-1 received bits.
//    * Bit 1 (transmission bit) must be 0, else set frame_err; reception continues.
//    * CRC7 (poly x^7+x^3+1, init 0) is fed with: short = tx+index+arg (the start bit is
//      pre-loaded as 0, so 40 bits in total); long = bits [127:8] only (120 bits).
//    * After the CRC field, the final tick checks the end bit (must be 1) and compares the CRC
//      field with the computed value if crc_en. Set flags, go DONE.
//  - DONE: done=1 for exactly one clk cycle, then IDLE.
//  - Flags and resp_* hold until the next accepted start.
//  - resp_* reflect the shift register and are valid only after done with timeout=0.
//  - Latency: done is asserted the cycle after the end-bit tick.
//  - abort is honoured in any state. It has priority over start and sample_en in the same cycle.
//  - rst assertion mid-frame: immediate return to reset values, no done.
//  - bit_cnt width: $clog2(LONG_BITS); no wrap is possible because of the explicit end compare.
// STRUCTURE
//  - sd_pkg: state enum {IDLE, WAIT_START, RECEIVE, DONE}, CRC7_POLY = 7'h09,
//    SHORT_BITS/LONG_BITS defaults, and the CRC field offset constants.
//  - Sub-module sd_crc7: serial CRC7 with ports clk, rst, clear, en, din, crc[6:0]. It is also
//    reused by the command generator.
// TESTING
//  1. Short R1, crc_en=1: frame 0x11_00000900 + CRC 0x33 + end 1 -> done after the last tick;
//     resp_index=6'h11, resp_arg=32'h00000900, all flags 0.
//  2. Same frame with CRC field 0x32 -> done, crc_err=1; resp fields still captured.
//  3. Frame 0x40_00000000 + CRC 0x4A (tx bit=1) -> frame_err=1. Repeat with end bit 0
//     -> frame_err=1.
//  4. cmd_in held 1 after start, TIMEOUT_TICKS=64 -> done on tick 64, timeout=1, busy low next.
//     Start bit exactly on tick 64 -> no timeout, normal receive.
//  5. R2: long_resp=1, 136-bit frame with known CID and correct CRC -> resp_long matches,
//     crc_err=0. R3 with crc_en=0 and CRC field 7'h7F -> crc_err=0.
//  6. abort at bit 20 and rst low at bit 30 -> IDLE, no done. A new start then decodes
//     frame 1 correctly. sample_en gaps of 3 cycles between ticks -> identical results.

Source files
------------

// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sd_pkg
//  Description : Shared constants for the SD CMD-line response path.
//  Revision    : 1.0 - initial release
// ============================================================================
package sd_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_START = 2'd1;
    localparam logic [1:0] ST_RECEIVE    = 2'd2;
    localparam logic [1:0] ST_DONE       = 2'd3;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam int SHORT_BITS_DEF = 48;
    localparam int LONG_BITS_DEF  = 136;

    // Frame tail after the CRC-covered payload: 7 CRC bits plus the end bit.
    localparam int CRC_TAIL_BITS     = 8;
    localparam int CRC_FIELD_W       = 7;
    localparam int LONG_PAYLOAD_BITS = 120;

endpackage
`default_nettype wire

// File: rtl/sd_crc7.sv
`default_nettype none
// ============================================================================
//  Module      : sd_crc7
//  Description : Bit-serial CRC7 (x^7+x^3+1, init 0), shared with the command generator.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] r_crc;
    logic       w_fb;

    assign w_fb = din ^ r_crc[6];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_crc <= 7'h00;
        end else if (clear) begin
            r_crc <= 7'h00;
        end else if (en) begin
            r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);
        end
    end

    assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/sd_cmd_resp_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : sd_cmd_resp_receiver
//  Description : Host-side SD CMD-line response receiver (48/136-bit, CRC7 + framing check).
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_cmd_resp_receiver
    import sd_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 64,
    parameter int SHORT_BITS    = SHORT_BITS_DEF,
    parameter int LONG_BITS     = LONG_BITS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         long_resp,
    input  logic         crc_en,
    input  logic         abort,
    input  logic         sample_en,
    input  logic         cmd_in,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output logic         crc_err,
    output logic         frame_err,
    output logic [5:0]   resp_index,
    output logic [31:0]  resp_arg,
    output logic [126:0] resp_long
);

    localparam int CW  = $clog2(LONG_BITS);
    localparam int TW  = $clog2(TIMEOUT_TICKS + 1);
    // The transmission bit of a long frame is shifted out of the top; nothing reads it.
    localparam int SRW = LONG_BITS - 2;

    localparam logic [CW-1:0] C_SHORT_LAST     = CW'(SHORT_BITS - 1);
    localparam logic [CW-1:0] C_LONG_LAST      = CW'(LONG_BITS - 1);
    localparam logic [CW-1:0] C_SHORT_CRC_LAST = CW'(SHORT_BITS - 1 - CRC_TAIL_BITS);
    localparam logic [CW-1:0] C_LONG_CRC_LAST  = CW'(LONG_BITS - 1 - CRC_TAIL_BITS);
    localparam logic [CW-1:0] C_LONG_CRC_FIRST = CW'(LONG_BITS - CRC_TAIL_BITS - LONG_PAYLOAD_BITS);
    localparam logic [TW-1:0] C_TICK_LAST      = TW'(TIMEOUT_TICKS - 1);

    logic [1:0]     r_state;
    logic           r_long;
    logic           r_crc_en;
    logic [TW-1:0]  r_tick_cnt;
    logic [CW-1:0]  r_bit_cnt;
    logic [SRW-1:0] r_sr;
    logic           r_timeout;
    logic           r_crc_err;
    logic           r_frame_err;

    logic [CW-1:0]  w_bit_num;
    logic           w_final;
    logic           w_crc_span;
    logic           w_crc_clear;
    logic           w_crc_feed;
    logic [6:0]     w_crc;

    // w_bit_num is the 1-based position (after the start bit) of the bit sampled this tick.
    assign w_bit_num  = r_bit_cnt + CW'(1);
    assign w_final    = (w_bit_num == (r_long ? C_LONG_LAST : C_SHORT_LAST));
    assign w_crc_span = r_long ? ((w_bit_num >= C_LONG_CRC_FIRST) && (w_bit_num <= C_LONG_CRC_LAST))
                               : (w_bit_num <= C_SHORT_CRC_LAST);

    assign w_crc_clear = !abort && sample_en && !cmd_in && (r_state == ST_WAIT_START);
    assign w_crc_feed  = !abort && sample_en && w_crc_span && (r_state == ST_RECEIVE);

    sd_crc7 u_crc7 (
        .clk   (clk),
        .rst   (rst),
        .clear (w_crc_clear),
        .en    (w_crc_feed),
        .din   (cmd_in),
        .crc   (w_crc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_long      <= 1'b0;
            r_crc_en    <= 1'b0;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_sr        <= '0;
            r_timeout   <= 1'b0;
            r_crc_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (abort) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_long      <= long_resp;
                        r_crc_en    <= crc_en;
                        r_tick_cnt  <= '0;
                        r_sr        <= '0;
                        r_timeout   <= 1'b0;
                        r_crc_err   <= 1'b0;
                        r_frame_err <= 1'b0;
                        r_state     <= ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    if (sample_en) begin
                        if (!cmd_in) begin
                            r_bit_cnt <= '0;
                            r_state   <= ST_RECEIVE;
                        end else if (r_tick_cnt == C_TICK_LAST) begin
                            r_timeout <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end
                ST_RECEIVE: begin
                    if (sample_en) begin
                        r_sr      <= {r_sr[SRW-2:0], cmd_in};
                        r_bit_cnt <= w_bit_num;
                        if ((w_bit_num == CW'(1)) && cmd_in) begin
                            r_frame_err <= 1'b1;
                        end
                        // On the end-bit tick the CRC field still sits in the low shift bits.
                        if (w_final) begin
                            if (!cmd_in) begin
                                r_frame_err <= 1'b1;
                            end
                            if (r_crc_en && (r_sr[CRC_FIELD_W-1:0] != w_crc)) begin
                                r_crc_err <= 1'b1;
                            end
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign timeout    = r_timeout;
    assign crc_err    = r_crc_err;
    assign frame_err  = r_frame_err;
    assign resp_index = r_long ? r_sr[LONG_BITS-3 -: 6] : r_sr[SHORT_BITS-3 -: 6];
    assign resp_arg   = r_sr[SHORT_BITS-9 -: 32];
    assign resp_long  = r_sr[LONG_BITS-9 -: 127];

endmodule
`default_nettype wire
